wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback arbiter directly upstream of the regfile write port (we/rd_addr/rd_data). It merges two result sources into that single port.
- Source one is the single-cycle ALU pipeline result, which is normal priority and has no queue.
- Source two is the long-latency multiply/divide unit (MDU) result, delivered by valid/ready handshake into a small FIFO.
- Starvation guard: an aged MDU entry takes the write port and stalls the ALU for one cycle.

Parameters:
- DEPTH, 4, MDU result FIFO entries; power of two, >=2.
- STARVE_LIMIT, 8, cycles the FIFO head may wait before it forces priority; >=1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-low reset; rst=0 resets at the clock edge.
- alu_valid  input  1  ALU result present this cycle.
- alu_rd  input  5  ALU destination register.
- alu_data  input  32  ALU result.
- alu_stall  output  1  ALU result not consumed this cycle; upstream holds alu_valid/alu_rd/alu_data stable.
- mdu_valid  input  1  MDU result offered.
- mdu_ready  output  1  FIFO can accept an MDU result.
- mdu_rd  input  5  MDU destination register.
- mdu_data  input  32  MDU result.
- we  output  1  regfile write enable.
- rd_addr  output  5  regfile write address.
- rd_data  output  32  regfile write data.
- q_count  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst=0 at edge):
  - we=0, rd_addr=0, rd_data=0, q_count=0, age=0; FIFO contents discarded.
  - While rst=0: mdu_ready=0 and alu_stall=0.
  - Reset mid-operation drops all queued entries; they are never written.
- mdu_ready = rst && (q_count < DEPTH).
  - Depends only on registered count. A pop in the same cycle does not raise ready.
- MDU accept = mdu_valid && mdu_ready.
  - mdu_rd != 0: entry pushed at FIFO tail.
  - mdu_rd == 0: entry consumed and discarded; no push.
- FIFO head eligibility: an entry becomes eligible the cycle after it is pushed. There is no same-cycle bypass.
- age counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs; saturates at STARVE_LIMIT.
  - Clears to 0 on a pop or when the FIFO is empty.
- starve = (age == STARVE_LIMIT) && (q_count != 0). This is a function of registered state only.
- Per-cycle selection, in priority order:
  1. starve: pop head, write it; alu_stall=1; ALU inputs ignored this cycle.
  2. alu_valid && alu_rd != 0: write ALU result; no pop.
  3. FIFO non-empty (ALU idle, or alu_rd == 0): pop head, write it.
  4. Otherwise: no write.
- alu_valid with alu_rd == 0 and no stall: result consumed, not written (we=0 unless a pop fills the slot).
- alu_stall is combinational from starve only. There is no path from alu_* or mdu_* inputs to alu_stall or mdu_ready.
- Output timing:
  - we/rd_addr/rd_data are registered and reflect the selection one cycle later, i.e. ALU-to-regfile latency is 1 cycle.
  - Minimum MDU accept-to-we latency is 2 cycles.
  - When no write occurs, we=0 and rd_addr/rd_data hold their previous values.
- Simultaneous push and pop: allowed; q_count unchanged.
- Full FIFO with a pop in the same cycle: push is not allowed (ready was 0).
- FIFO order: strict in-order pop. Pointers wrap modulo DEPTH.
- Never drives we=1 with rd_addr=0.

Test Plan:
- Release reset; alu_valid=1, alu_rd=1, alu_data=32'hDEADBEEF for 1 cycle -> next edge we=1, rd_addr=1, rd_data=32'hDEADBEEF; following cycle we=0, rd_addr/rd_data unchanged.
- alu_valid=1, alu_rd=0, alu_data=32'hFFFFFFFF; also mdu_rd=0 accepted -> we stays 0; q_count stays 0.
- ALU idle; MDU push rd=5, data=32'h12345678 -> q_count=1 next cycle; we=1, rd_addr=5, rd_data=32'h12345678 two cycles after accept; q_count=0.
- alu_valid held high on rd=2; push MDU rd 10..14 back-to-back -> 4 accepted, mdu_ready=0 with q_count=4; rd=14 held until a pop; afterwards entries write in order 10,11,12,13,14.
- alu_valid held high (rd=3, data=1); one MDU entry rd=7 -> after 8 waiting cycles alu_stall=1 for exactly 1 cycle; we writes rd=7 next edge; the held ALU rd=3 writes the edge after.
- q_count=3 with ALU busy; drive rst=0 for one cycle -> q_count=0, we=0, mdu_ready=0 during reset; after release the 3 entries are never written.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU result, MDU handshake and regfile write port.
interface wb_arbiter_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned RW = 5;
    localparam int unsigned DW = 32;

    logic          alu_valid;
    logic [RW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          alu_stall;
    logic          mdu_valid;
    logic          mdu_ready;
    logic [RW-1:0] mdu_rd;
    logic [DW-1:0] mdu_data;
    logic          we;
    logic [RW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] q_count;

    modport master (
        output alu_valid, alu_rd, alu_data, mdu_valid, mdu_rd, mdu_data,
        input  alu_stall, mdu_ready, we, rd_addr, rd_data, q_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mdu_valid, mdu_rd, mdu_data,
        output alu_stall, mdu_ready, we, rd_addr, rd_data, q_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the single-cycle ALU result with queued MDU results
// onto the regfile write port, with an age-based override so MDU entries cannot starve.
module wb_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned GW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned RW = 5;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } wb_entry_t;

    wb_entry_t     mem_q [DEPTH];
    wb_entry_t     mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [GW-1:0] age_q, age_d;
    logic          we_q, we_d;
    logic [RW-1:0] rd_addr_q, rd_addr_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic empty_c, starve_c, ready_c, push_c, pop_c;

    // Ready and stall come from registered state only, never from the inputs.
    assign ready_c       = rst && (count_q < CW'(DEPTH));
    assign bus.mdu_ready = ready_c;
    assign bus.alu_stall = rst && starve_c;
    assign bus.we        = we_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.q_count   = count_q;

    always_comb begin
        empty_c   = (count_q == '0);
        starve_c  = (age_q == GW'(STARVE_LIMIT)) && !empty_c;
        push_c    = bus.mdu_valid && ready_c && (bus.mdu_rd != '0);
        pop_c     = 1'b0;
        we_d      = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;

        if (starve_c) begin
            pop_c     = 1'b1;
            we_d      = 1'b1;
            rd_addr_d = mem_q[rd_ptr_q].rd;
            rd_data_d = mem_q[rd_ptr_q].data;
        end else if (bus.alu_valid && (bus.alu_rd != '0)) begin
            we_d      = 1'b1;
            rd_addr_d = bus.alu_rd;
            rd_data_d = bus.alu_data;
        end else if (!empty_c) begin
            pop_c     = 1'b1;
            we_d      = 1'b1;
            rd_addr_d = mem_q[rd_ptr_q].rd;
            rd_data_d = mem_q[rd_ptr_q].data;
        end

        mem_d = mem_q;
        if (push_c) begin
            mem_d[wr_ptr_q] = '{rd: bus.mdu_rd, data: bus.mdu_data};
        end
        wr_ptr_d = push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_c  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Head age: counts waiting cycles, saturating at the starvation threshold.
        if (empty_c || pop_c) begin
            age_d = '0;
        end else if (age_q != GW'(STARVE_LIMIT)) begin
            age_d = age_q + GW'(1);
        end else begin
            age_d = age_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            age_q     <= '0;
            we_q      <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            age_q     <= age_d;
            we_q      <= we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage needs no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus queues expected regfile writes, a monitor checks them.
module tb_wb_arbiter;
    localparam int unsigned DEPTH        = 4;
    localparam int unsigned STARVE_LIMIT = 8;
    localparam int          PERIOD       = 9;   // starve pop every 9 cycles with ALU held busy

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.mdu_valid = 1'b0;
        bus.mdu_rd    = '0;
        bus.mdu_data  = '0;
    endtask

    // Monitor: every regfile write must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got rd=%0d data=%h", bus.rd_addr, bus.rd_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.rd_addr !== mon_e.rd || bus.rd_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL write got rd=%0d data=%h want rd=%0d data=%h",
                             bus.rd_addr, bus.rd_data, mon_e.rd, mon_e.data);
                end
            end
        end
    end

    // ALU held busy while n_mdu MDU entries are offered back-to-back.
    task automatic run_held(input logic [4:0] a_rd, input logic [31:0] a_data, input int n_mdu,
                            input logic [4:0] m_rd0, input logic [31:0] m_data0,
                            input int ncyc, input string tag);
        int   sent;
        logic rdy;
        sent          = 0;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = a_rd;
        bus.alu_data  = a_data;
        for (int c = 0; c < ncyc; c++) begin
            bit starve_exp;
            starve_exp    = (c > 0) && (c % PERIOD == 0) && (c / PERIOD <= n_mdu);
            bus.mdu_valid = (sent < n_mdu);
            bus.mdu_rd    = m_rd0 + 5'(sent);
            bus.mdu_data  = m_data0 + 32'(sent);
            @(negedge clk);
            check({tag, "_stall"}, 32'(bus.alu_stall), 32'(starve_exp));
            if (starve_exp)
                push_exp(m_rd0 + 5'(c / PERIOD - 1), m_data0 + 32'(c / PERIOD - 1));
            else
                push_exp(a_rd, a_data);
            if (n_mdu == 5 && c == 4) begin
                check({tag, "_full_count"}, 32'(bus.q_count), 32'd4);
                check({tag, "_full_ready"}, 32'(bus.mdu_ready), 32'd0);
            end
            if (n_mdu == 5 && c == 10)
                check({tag, "_ready_after_pop"}, 32'(bus.mdu_ready), 32'd1);
            rdy = bus.mdu_ready;
            tick();
            if (rdy && bus.mdu_valid) sent++;
        end
        bus.alu_valid = 1'b0;
        bus.mdu_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_we",      32'(bus.we),        32'd0);
        check("rst_rd_addr", 32'(bus.rd_addr),   32'd0);
        check("rst_rd_data", bus.rd_data,        32'd0);
        check("rst_q_count", 32'(bus.q_count),   32'd0);
        check("rst_ready",   32'(bus.mdu_ready), 32'd0);
        check("rst_stall",   32'(bus.alu_stall), 32'd0);

        // Single ALU write, then hold of address/data with we low.
        tick();
        rst           = 1'b1;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd1;
        bus.alu_data  = 32'hDEADBEEF;
        push_exp(5'd1, 32'hDEADBEEF);
        tick();
        idle_inputs();
        @(negedge clk);
        check("alu_we", 32'(bus.we), 32'd1);
        tick();
        @(negedge clk);
        check("idle_we",      32'(bus.we),      32'd0);
        check("hold_rd_addr", 32'(bus.rd_addr), 32'd1);
        check("hold_rd_data", bus.rd_data,      32'hDEADBEEF);

        // rd=0 on both sources: nothing written, nothing queued.
        tick();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'hFFFFFFFF;
        bus.mdu_valid = 1'b1;
        bus.mdu_rd    = 5'd0;
        bus.mdu_data  = 32'hAAAA5555;
        @(negedge clk);
        check("x0_ready", 32'(bus.mdu_ready), 32'd1);
        tick();
        idle_inputs();
        @(negedge clk);
        check("x0_we",      32'(bus.we),      32'd0);
        check("x0_q_count", 32'(bus.q_count), 32'd0);
        tick();
        @(negedge clk);
        check("x0_we_late", 32'(bus.we),      32'd0);
        check("x0_rd_addr", 32'(bus.rd_addr), 32'd1);

        // Lone MDU result: two-cycle accept-to-write latency.
        tick();
        bus.mdu_valid = 1'b1;
        bus.mdu_rd    = 5'd5;
        bus.mdu_data  = 32'h12345678;
        push_exp(5'd5, 32'h12345678);
        tick();
        idle_inputs();
        @(negedge clk);
        check("mdu_q_count1", 32'(bus.q_count), 32'd1);
        check("mdu_we_early", 32'(bus.we),      32'd0);
        tick();
        @(negedge clk);
        check("mdu_we",       32'(bus.we),      32'd1);
        check("mdu_rd_addr",  32'(bus.rd_addr), 32'd5);
        check("mdu_q_count0", 32'(bus.q_count), 32'd0);
        tick();

        // FIFO fill under a busy ALU; entries drain in order via starvation pops.
        run_held(5'd2, 32'h00000022, 5, 5'd10, 32'h00000100, 50, "fill");
        tick();

        // Single aged entry preempts the held ALU result for exactly one cycle.
        run_held(5'd3, 32'h00000001, 1, 5'd7, 32'h00000077, 12, "starve");
        tick();

        // Reset with three queued entries: they must never be written.
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd4;
        bus.alu_data  = 32'h00000044;
        for (int c = 0; c < 3; c++) begin
            bus.mdu_valid = 1'b1;
            bus.mdu_rd    = 5'(20 + c);
            bus.mdu_data  = 32'h00000200 + 32'(c);
            @(negedge clk);
            push_exp(5'd4, 32'h00000044);
            tick();
        end
        bus.mdu_valid = 1'b0;
        rst           = 1'b0;
        @(negedge clk);
        check("pre_rst_q_count", 32'(bus.q_count),   32'd3);
        check("in_rst_ready",    32'(bus.mdu_ready), 32'd0);
        check("in_rst_stall",    32'(bus.alu_stall), 32'd0);
        tick();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        check("post_rst_q_count", 32'(bus.q_count), 32'd0);
        check("post_rst_we",      32'(bus.we),      32'd0);
        check("post_rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        check("post_rst_rd_data", bus.rd_data,      32'd0);
        repeat (12) tick();
        @(negedge clk);
        check("final_q_count", 32'(bus.q_count),  32'd0);
        check("drain_pending", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
